// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between execute stage and data RAM: one request at a time,
// RV32 width decode, byte-lane masking/replication, load extraction and error flagging.
module lsu_mem_ctrl #(
  parameter int unsigned API_ADDR_WIDTH = 32,
  parameter int unsigned API_DATA_WIDTH = 32,
  parameter int unsigned MEM_LATENCY    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_store,
  input  logic [2:0]                  req_funct3,
  input  logic [API_ADDR_WIDTH-1:0]   req_addr,
  input  logic [API_DATA_WIDTH-1:0]   req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [API_DATA_WIDTH-1:0]   resp_rdata,
  output logic                        resp_misaligned,
  output logic                        resp_illegal,
  output logic                        mem_en,
  output logic [API_ADDR_WIDTH-1:0]   mem_address_o,
  output logic [API_DATA_WIDTH-1:0]   mem_data_o,
  output logic [API_DATA_WIDTH/8-1:0] mem_wr_mask_o,
  input  logic [API_DATA_WIDTH-1:0]   mem_data_i
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MASK_W = API_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;

  logic                accept;
  logic                illegal_c, misaligned_c;
  logic [MASK_W-1:0]   st_mask_c;
  logic [API_DATA_WIDTH-1:0] st_data_c, lane_c, ld_data_c;

  logic                mem_en_d, resp_valid_d, mis_d, ill_d;
  logic [MASK_W-1:0]   mask_d;
  logic [API_ADDR_WIDTH-1:0] addr_d;
  logic [API_DATA_WIDTH-1:0] data_d, rdata_d;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Request decode from the live inputs, used only on the acceptance cycle
  always_comb begin
    illegal_c = req_store ? (req_funct3 > 3'b010)
                          : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    case (req_funct3[1:0])
      2'b01:   misaligned_c = req_addr[0];
      2'b10:   misaligned_c = (req_addr[1:0] != 2'b00);
      default: misaligned_c = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        st_mask_c = 4'b0001 << req_addr[1:0];
        st_data_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_mask_c = 4'b0011 << req_addr[1:0];
        st_data_c = {2{req_wdata[15:0]}};
      end
      default: begin
        st_mask_c = 4'b1111;
        st_data_c = req_wdata;
      end
    endcase
  end

  // Lane select and extension of the sampled RAM word
  always_comb begin
    lane_c = mem_data_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b001:  ld_data_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b100:  ld_data_c = {24'h0, lane_c[7:0]};
      3'b101:  ld_data_c = {16'h0, lane_c[15:0]};
      default: ld_data_c = lane_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: if (accept) begin
        if (illegal_c || misaligned_c) state_d = RESP;
        else if (req_store)            state_d = WRITE;
        else begin
          state_d = READ;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
        end
      end
      READ:  if (cnt == '0) state_d = RESP; else cnt_d = cnt - 1'b1;
      WRITE: state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; fields hold unless the state says otherwise
  always_comb begin
    mem_en_d     = 1'b0;
    mask_d       = '0;
    addr_d       = mem_address_o;
    data_d       = mem_data_o;
    resp_valid_d = resp_valid;
    rdata_d      = resp_rdata;
    mis_d        = resp_misaligned;
    ill_d        = resp_illegal;
    case (state)
      IDLE: if (accept) begin
        if (illegal_c || misaligned_c) begin
          resp_valid_d = 1'b1;
          rdata_d      = '0;
          ill_d        = illegal_c;
          mis_d        = misaligned_c & ~illegal_c;
        end else begin
          mem_en_d = 1'b1;
          addr_d   = {req_addr[API_ADDR_WIDTH-1:2], 2'b00};
          if (req_store) begin
            mask_d = st_mask_c;
            data_d = st_data_c;
          end
        end
      end
      READ: if (cnt != '0) mem_en_d = 1'b1;
      else begin
        resp_valid_d = 1'b1;
        rdata_d      = ld_data_c;
        mis_d        = 1'b0;
        ill_d        = 1'b0;
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        rdata_d      = '0;
        mis_d        = 1'b0;
        ill_d        = 1'b0;
      end
      RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        rdata_d      = '0;
        mis_d        = 1'b0;
        ill_d        = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en          <= 1'b0;
      mem_wr_mask_o   <= '0;
      mem_address_o   <= '0;
      mem_data_o      <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      funct3_q        <= '0;
      off_q           <= '0;
    end else begin
      mem_en          <= mem_en_d;
      mem_wr_mask_o   <= mask_d;
      mem_address_o   <= addr_d;
      mem_data_o      <= data_d;
      resp_valid      <= resp_valid_d;
      resp_rdata      <= rdata_d;
      resp_misaligned <= mis_d;
      resp_illegal    <= ill_d;
      if (accept) begin
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus random requests checked against a
// byte-addressed shadow memory model, with a latency-accurate RAM stub.
module tb_lsu_mem_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_store, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_misaligned, resp_illegal, mem_en;
  logic [31:0] resp_rdata, mem_address_o, mem_data_o, mem_data_i;
  logic [3:0]  mem_wr_mask_o;

  logic [31:0] ram [64];
  logic        ram_init;
  int          rd_run;
  logic [7:0]  shadow [256];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int resp_cyc; int en_cnt; int addr_lo_bad;
    logic [3:0] mask; logic [31:0] wdata; logic [31:0] addr;
    logic [31:0] rdata; logic mis; logic ill;
    int hold_changes; int hold_busy;
    logic ready_before; logic valid_after; logic ready_after;
  } obs_t;

  typedef struct {
    logic ill; logic mis; logic [31:0] rd; int cyc; int en;
    logic [3:0] mask; logic [31:0] wd;
  } exp_t;

  lsu_mem_ctrl #(.API_ADDR_WIDTH(32), .API_DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .resp_illegal(resp_illegal), .mem_en(mem_en), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_wr_mask_o(mem_wr_mask_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  // RAM stub: byte-masked writes; read data valid only in the LAT-th read cycle
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (mem_en && mem_wr_mask_o != 4'b0) begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_mask_o[b]) ram[mem_address_o[7:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
    end
    rd_run <= (mem_en && mem_wr_mask_o == 4'b0) ? rd_run + 1 : 0;
  end
  assign mem_data_i = (mem_en && mem_wr_mask_o == 4'b0 && rd_run == LAT - 1)
                      ? ram[mem_address_o[7:2]] : 32'hDEAD_BEEF;

  // Reference model: legality, alignment and data computed from byte-level rules
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int sz;
    int base;
    logic [31:0] val;
    sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    base = int'(a[7:0]);
    e.ill  = st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.mis  = !e.ill && (base % sz != 0);
    e.rd   = '0; e.mask = '0; e.wd = '0; e.en = 0; e.cyc = 1;
    if (!e.ill && !e.mis) begin
      if (st) begin
        e.en = 1; e.cyc = 2;
        for (int i = 0; i < sz; i++) begin
          shadow[base + i]        = wd[8*i +: 8];
          e.mask[(base % 4) + i]  = 1'b1;
        end
        for (int j = 0; j < 4; j++) e.wd[8*j +: 8] = wd[8*(j % sz) +: 8];
      end else begin
        e.en = LAT; e.cyc = LAT + 1;
        val = '0;
        for (int i = 0; i < sz; i++) val[8*i +: 8] = shadow[base + i];
        if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8*sz));
        e.rd = val;
      end
    end
  endtask

  // Drive one request, observe the RAM side and the response; hold RESP for 'hold' cycles
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, output obs_t o);
    o.resp_cyc = -1; o.en_cnt = 0; o.addr_lo_bad = 0; o.mask = 'x; o.wdata = 'x;
    o.addr = 'x; o.rdata = 'x; o.mis = 1'bx; o.ill = 1'bx; o.hold_changes = 0;
    o.hold_busy = 0; o.valid_after = 1'bx; o.ready_after = 1'bx;
    @(negedge clk);
    o.ready_before = req_ready;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_en) begin
        o.en_cnt++;
        o.mask = mem_wr_mask_o; o.wdata = mem_data_o; o.addr = mem_address_o;
        if (mem_address_o[1:0] != 2'b00) o.addr_lo_bad++;
      end
      if (resp_valid) begin
        o.resp_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (o.resp_cyc > 0) begin
      o.rdata = resp_rdata; o.mis = resp_misaligned; o.ill = resp_illegal;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (!resp_valid || resp_rdata !== o.rdata || resp_misaligned !== o.mis ||
            resp_illegal !== o.ill) o.hold_changes++;
        if (req_ready || mem_en) o.hold_busy++;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      o.valid_after = resp_valid; o.ready_after = req_ready;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ram_init = 1'b1; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({resp_valid, resp_rdata, resp_misaligned, resp_illegal, mem_en, mem_wr_mask_o,
         mem_address_o, mem_data_o} !== '0) begin
      bad++; $display("FAIL reset_outputs got_nonzero valid=%b en=%b addr=%h data=%h",
                      resp_valid, mem_en, mem_address_o, mem_data_o);
    end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    reset = 1'b0; ram_init = 1'b0;
  endtask

  task automatic test_store_byte();
    obs_t o; exp_t e;
    model(1'b1, 3'b000, 32'h23, 32'h0000_00A5, e);
    do_req(1'b1, 3'b000, 32'h23, 32'h0000_00A5, 0, o);
    total++; if (o.mask !== 4'b1000) begin bad++; $display("FAIL sb_mask got=%b exp=1000", o.mask); end
    total++; if (o.wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_data got=%h exp=a5a5a5a5", o.wdata); end
    total++; if (o.addr !== 32'h20) begin bad++; $display("FAIL sb_addr got=%h exp=00000020", o.addr); end
    total++; if (o.en_cnt !== 1 || o.resp_cyc !== 2) begin
      bad++; $display("FAIL sb_timing en=%0d resp_cyc=%0d exp en=1 resp_cyc=2", o.en_cnt, o.resp_cyc);
    end
    total++; if ({o.mis, o.ill} !== 2'b00) begin bad++; $display("FAIL sb_flags got=%b%b exp=00", o.mis, o.ill); end
  endtask

  task automatic test_half_signed();
    obs_t o; exp_t e;
    model(1'b1, 3'b001, 32'h22, 32'h0000_8001, e);
    do_req(1'b1, 3'b001, 32'h22, 32'h0000_8001, 0, o);
    total++; if (o.mask !== 4'b1100 || o.wdata !== 32'h8001_8001) begin
      bad++; $display("FAIL sh_lanes mask=%b data=%h exp 1100 80018001", o.mask, o.wdata);
    end
    do_req(1'b0, 3'b001, 32'h22, 32'h0, 0, o);
    total++; if (o.rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_rdata got=%h exp=ffff8001", o.rdata); end
    do_req(1'b0, 3'b101, 32'h22, 32'h0, 0, o);
    total++; if (o.rdata !== 32'h0000_8001) begin bad++; $display("FAIL lhu_rdata got=%h exp=00008001", o.rdata); end
  endtask

  logic [31:0] lb_exp  [4] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
  logic [31:0] lbu_exp [4] = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};

  task automatic test_byte_lanes();
    obs_t o; exp_t e;
    model(1'b1, 3'b010, 32'h20, 32'h80FF_7F01, e);
    do_req(1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 0, o);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 3'b000, 32'h20 + i, 32'h0, 0, o);
      total++; if (o.rdata !== lb_exp[i]) begin bad++; $display("FAIL lb_lane%0d got=%h exp=%h", i, o.rdata, lb_exp[i]); end
      do_req(1'b0, 3'b100, 32'h20 + i, 32'h0, 0, o);
      total++; if (o.rdata !== lbu_exp[i]) begin bad++; $display("FAIL lbu_lane%0d got=%h exp=%h", i, o.rdata, lbu_exp[i]); end
    end
  endtask

  task automatic test_errors();
    obs_t o;
    do_req(1'b0, 3'b010, 32'h22, 32'h0, 0, o);
    total++; if (o.resp_cyc !== 1 || o.en_cnt !== 0) begin
      bad++; $display("FAIL lw_mis_timing resp_cyc=%0d en=%0d exp 1 0", o.resp_cyc, o.en_cnt);
    end
    total++; if ({o.mis, o.ill} !== 2'b10 || o.rdata !== 32'h0) begin
      bad++; $display("FAIL lw_mis_flags mis=%b ill=%b rdata=%h exp 1 0 0", o.mis, o.ill, o.rdata);
    end
    do_req(1'b1, 3'b100, 32'h21, 32'h55, 0, o);
    total++; if ({o.ill, o.mis} !== 2'b10 || o.en_cnt !== 0) begin
      bad++; $display("FAIL sb_illegal ill=%b mis=%b en=%0d exp 1 0 0", o.ill, o.mis, o.en_cnt);
    end
  endtask

  task automatic test_latency_backpressure();
    obs_t o; exp_t e;
    model(1'b1, 3'b010, 32'h40, 32'hC0DE_1234, e);
    do_req(1'b1, 3'b010, 32'h40, 32'hC0DE_1234, 0, o);
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 5, o);
    total++; if (o.en_cnt !== LAT || o.resp_cyc !== LAT + 1) begin
      bad++; $display("FAIL lat_timing en=%0d resp_cyc=%0d exp %0d %0d", o.en_cnt, o.resp_cyc, LAT, LAT + 1);
    end
    total++; if (o.rdata !== 32'hC0DE_1234) begin bad++; $display("FAIL lat_rdata got=%h exp=c0de1234", o.rdata); end
    total++; if (o.hold_changes !== 0 || o.hold_busy !== 0) begin
      bad++; $display("FAIL bp_stall changes=%0d busy=%0d exp 0 0", o.hold_changes, o.hold_busy);
    end
    total++; if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
      bad++; $display("FAIL bp_release valid=%b ready=%b exp 0 1", o.valid_after, o.ready_after);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int acc, good;
    model(1'b1, 3'b010, 32'h80, 32'h1234_5678, e);
    for (int pass = 0; pass < 2; pass++) begin
      acc = 0; good = 0;
      @(negedge clk);
      req_valid = 1'b1; req_store = (pass == 0); req_funct3 = 3'b010;
      req_addr = 32'h80; req_wdata = 32'h1234_5678; resp_ready = 1'b1;
      for (int c = 0; c < 12 + 3 * pass; c++) begin
        if (c > 0) @(negedge clk);
        if (req_ready) acc++;
        if (resp_valid && resp_rdata === ((pass == 0) ? 32'h0 : 32'h1234_5678)) good++;
      end
      req_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      resp_ready = 1'b0;
      total++; if (acc !== 4 - pass) begin bad++; $display("FAIL b2b_accepts pass=%0d got=%0d exp=%0d", pass, acc, 4 - pass); end
      total++; if (good !== 3 + (1 - pass)) begin bad++; $display("FAIL b2b_resps pass=%0d got=%0d exp=%0d", pass, good, 4 - pass); end
    end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rst_read_active en=%b exp=1", mem_en); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (mem_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_read en=%b ready=%b valid=%b exp 0 1 0", mem_en, req_ready, resp_valid);
    end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (resp_valid) seen++; end
    resp_ready = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_resp got=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic st; logic [2:0] f3; logic [31:0] a, wd; int hold;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255)); wd = $urandom; hold = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      model(st, f3, a, wd, e);
      do_req(st, f3, a, wd, hold, o);
      total++; if (o.resp_cyc !== e.cyc || o.en_cnt !== e.en || o.addr_lo_bad !== 0) begin
        bad++; $display("FAIL rnd_timing i=%0d resp_cyc=%0d en=%0d lo=%0d exp %0d %0d 0", i, o.resp_cyc, o.en_cnt, o.addr_lo_bad, e.cyc, e.en);
      end
      total++; if (o.rdata !== e.rd || o.ill !== e.ill || o.mis !== e.mis) begin
        bad++; $display("FAIL rnd_resp i=%0d st=%b f3=%0d a=%h got=%h/%b%b exp=%h/%b%b", i, st, f3, a, o.rdata, o.ill, o.mis, e.rd, e.ill, e.mis);
      end
      total++; if (o.ready_before !== 1'b1 || o.hold_changes !== 0 || o.hold_busy !== 0 ||
                   o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
        bad++; $display("FAIL rnd_handshake i=%0d rb=%b ch=%0d busy=%0d va=%b ra=%b", i, o.ready_before, o.hold_changes, o.hold_busy, o.valid_after, o.ready_after);
      end
      if (!e.ill && !e.mis) begin
        total++; if (o.addr !== {a[31:2], 2'b00} || o.mask !== e.mask) begin
          bad++; $display("FAIL rnd_ram i=%0d addr=%h mask=%b exp %h %b", i, o.addr, o.mask, {a[31:2], 2'b00}, e.mask);
        end
        if (st) begin
          total++; if (o.wdata !== e.wd) begin bad++; $display("FAIL rnd_wdata i=%0d got=%h exp=%h", i, o.wdata, e.wd); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_half_signed();
    test_byte_lanes();
    test_errors();
    test_latency_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
